instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage between the core PC logic and `program_memory`. Holds the fetch PC, drives the request/ack handshake to program memory, and buffers returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake. Branch, jump, trap and `mret` redirects from execute flush the FIFO and restart fetch at the new PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
- BUF_DEPTH, 2, instruction FIFO entries; power of two, ≥2

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- o_pc  output  32  fetch address to program memory
- o_instruction_request  output  1  fetch request to program memory
- i_instruction  input  32  instruction data from program memory
- i_ack  input  1  program memory acknowledge; may rise in the same cycle as the request
- i_redirect  input  1  flush and restart fetch
- i_redirect_pc  input  32  new fetch PC; bits [1:0] ignored (treated as 00)
- o_valid  output  1  FIFO head valid to decode
- o_instr  output  32  FIFO head instruction
- o_instr_pc  output  32  PC of FIFO head instruction
- i_ready  input  1  decode accepts head this cycle

## Operation
- State machine states:
  - RESET: entered while i_rst_n=0. Next cycle goes to FETCH.
  - FETCH: o_instruction_request=1.
  - FULL: o_instruction_request=0. Entered when count==BUF_DEPTH.
- Push: in FETCH, when i_ack=1 at the edge:
  - FIFO[wr_ptr] <= {i_instruction, o_pc}
  - o_pc <= o_pc+4, wrapping modulo 2^32
  - count increments unless a pop occurs in the same cycle
- Pop: when o_valid && i_ready, rd_ptr advances and count decrements.
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- Pointers are log2(BUF_DEPTH) bits and wrap naturally.
- FETCH→FULL: when a push without a pop makes count==BUF_DEPTH.
- FULL→FETCH: on any pop. Request rises the cycle after the pop.
- While in FULL, i_ack and i_instruction are ignored.
- Redirect (i_redirect=1 at the edge):
  - count, rd_ptr and wr_ptr are cleared
  - o_pc <= {i_redirect_pc[31:2],2'b00}
  - state goes to FETCH
  - any same-cycle ack is discarded
  - any same-cycle pop is void; decode must treat its own slot as killed
- Priority: reset > redirect > push/pop.
- o_valid = (count != 0). o_instr and o_instr_pc come from FIFO[rd_ptr].

## Timing
- Reset values: o_pc=RESET_PC, o_instruction_request=0, o_valid=0, o_instr=0, o_instr_pc=0. All FIFO entries are cleared to 0.
- First request: o_instruction_request=1 in the first cycle after i_rst_n goes high, with o_pc=RESET_PC.
- Latency with same-cycle ack: an instruction fetched in cycle N is on o_instr with o_valid=1 in cycle N+1.
- Throughput: one instruction per cycle sustained while decode keeps i_ready=1.
- Multi-cycle ack: o_pc and the request are held stable until i_ack is sampled high.
- Redirect in cycle N: request is issued at the new PC in cycle N+1, and o_valid=0 in N+1.
- Reset asserted mid-operation: all state returns to reset values on the next edge. In-flight acks are dropped.

## Test plan
- Reset release with same-cycle ack and i_ready=1, memory words 0x00000013, 0x00100093, 0x00200113:
  - o_pc steps 0x0→0x4→0x8
  - o_instr/o_instr_pc appear one cycle after each fetch, one per cycle
- Decode stall, i_ready=0 for 5 cycles, BUF_DEPTH=2:
  - after 2 pushes the request drops and o_pc holds at 0x8
  - releasing i_ready pops 0x0 then 0x4; the request re-rises the cycle after the first pop
- Redirect to 0x0000_0103 while the FIFO holds 2 entries and a same-cycle ack is present:
  - next cycle o_valid=0, o_pc=0x100, request=1
  - the discarded ack never appears on o_instr
- Ack delayed 3 cycles after the request:
  - o_pc and the request stay stable throughout
  - exactly one push per ack; no duplicate entries
- PC wrap: redirect to 0xFFFF_FFFC, one fetch → next o_pc=0x0000_0000.
- Reset asserted while full and mid-request: after one edge all outputs equal reset values; request rises in the cycle after release.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the fetch PC, handshakes with program memory, and
// buffers returned instructions with their PCs for decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_pc,
    output logic        o_instruction_request,
    input  logic [31:0] i_instruction,
    input  logic        i_ack,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_ready
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_req;
    logic             w_req_next;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      r_pc;
    logic [31:0]      r_mem_instr [BUF_DEPTH];
    logic [31:0]      r_mem_pc    [BUF_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Next-state, push/pop qualification and next request value; redirect overrides all.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_pop        = (r_count != '0) && i_ready;
        w_req_next   = 1'b0;
        case (r_state)
            ST_RESET: w_state_next = ST_FETCH;
            ST_FETCH: begin
                w_push = i_ack;
                if (i_ack && !w_pop && (r_count == (FULL_CNT - CNT_W'(1)))) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: w_state_next = ST_RESET;
        endcase
        if (i_redirect) begin
            w_state_next = ST_FETCH;
            w_push       = 1'b0;
            w_pop        = 1'b0;
        end
        w_req_next = (w_state_next == ST_FETCH);
    end

    // State register and registered fetch request.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_RESET;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= w_req_next;
        end
    end

    // Fetch PC, FIFO storage, pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (i_redirect) begin
            r_pc     <= {i_redirect_pc[31:2], 2'b00};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= i_instruction;
                r_mem_pc[r_wr_ptr]    <= r_pc;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
                r_pc                  <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pc                  = r_pc;
    assign o_instruction_request = r_req;
    assign o_valid               = (r_count != '0);
    assign o_instr               = r_mem_instr[r_rd_ptr];
    assign o_instr_pc            = r_mem_pc[r_rd_ptr];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instruction_fetch;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] o_pc;
    logic        o_req;
    logic [31:0] i_instruction;
    logic        ack;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        ready;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .o_pc                  (o_pc),
        .o_instruction_request (o_req),
        .i_instruction         (i_instruction),
        .i_ack                 (ack),
        .i_redirect            (redirect),
        .i_redirect_pc         (redirect_pc),
        .o_valid               (o_valid),
        .o_instr               (o_instr),
        .o_instr_pc            (o_instr_pc),
        .i_ready               (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory contents: the three test-plan words, a unique pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            default: return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
        endcase
    endfunction

    assign i_instruction = mem_word(o_pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {instr, pc}, the fetch PC, and whether fetch has started.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_alive = 0;
    bit          m_push;
    bit          m_pop;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc    = 32'h0;
            m_alive = 0;
        end else if (redirect) begin
            m_q.delete();
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_alive = 1;
        end else begin
            m_pop  = (m_q.size() > 0) && ready;
            m_push = m_alive && (m_q.size() < int'(DEPTH)) && ack;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                m_q.push_back({mem_word(m_pc), m_pc});
                m_pc = m_pc + 32'd4;
            end
            m_alive = 1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_pc", o_pc, m_pc);
            chk("m_req", 32'(o_req), 32'(m_alive && (m_q.size() < int'(DEPTH))));
            chk("m_valid", 32'(o_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("m_instr", o_instr, m_q[0].instr);
                chk("m_instr_pc", o_instr_pc, m_q[0].pc);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        cyc();
        redirect    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ack = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        cyc();
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_req", 32'(o_req), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_instr_pc", o_instr_pc, 32'h0);
        check_en = 1;

        // Release with same-cycle ack, decode always ready.
        rst_n = 1'b1; ack = 1'b1; ready = 1'b1;
        cyc();
        chk("first_req", 32'(o_req), 32'h1);
        chk("first_pc", o_pc, 32'h0);
        chk("first_valid", 32'(o_valid), 32'h0);
        cyc();
        chk("s1_pc", o_pc, 32'h4);
        chk("s1_instr", o_instr, 32'h0000_0013);
        chk("s1_ipc", o_instr_pc, 32'h0);
        cyc();
        chk("s2_pc", o_pc, 32'h8);
        chk("s2_instr", o_instr, 32'h0010_0093);
        chk("s2_ipc", o_instr_pc, 32'h4);
        cyc();
        chk("s3_pc", o_pc, 32'hC);
        chk("s3_instr", o_instr, 32'h0020_0113);
        chk("s3_ipc", o_instr_pc, 32'h8);

        // Decode stall fills the buffer and drops the request.
        ready = 1'b0;
        do_redirect(32'h0);
        chk("stall_redir_pc", o_pc, 32'h0);
        cyc();
        cyc();
        repeat (3) begin
            cyc();
            chk("stall_pc", o_pc, 32'h8);
            chk("stall_req", 32'(o_req), 32'h0);
            chk("stall_ipc", o_instr_pc, 32'h0);
        end
        ready = 1'b1;
        cyc();
        chk("unstall_req", 32'(o_req), 32'h1);
        chk("unstall_ipc", o_instr_pc, 32'h4);
        cyc();
        chk("unstall2_ipc", o_instr_pc, 32'h8);
        chk("unstall2_pc", o_pc, 32'hC);

        // Redirect while full with an ack present; then while fetching with an ack.
        ready = 1'b0; ack = 1'b1;
        do_redirect(32'h200);
        cyc();
        cyc();
        chk("full_req", 32'(o_req), 32'h0);
        ready = 1'b1;
        do_redirect(32'h0000_0103);
        chk("redir_valid", 32'(o_valid), 32'h0);
        chk("redir_pc", o_pc, 32'h100);
        chk("redir_req", 32'(o_req), 32'h1);
        cyc();
        chk("redir_ipc", o_instr_pc, 32'h100);
        chk("redir_instr", o_instr, mem_word(32'h100));
        ready = 1'b0;
        do_redirect(32'h300);
        chk("redir2_valid", 32'(o_valid), 32'h0);
        chk("redir2_pc", o_pc, 32'h300);

        // Ack delayed three cycles after the request.
        ack = 1'b0; ready = 1'b1;
        do_redirect(32'h40);
        repeat (3) begin
            cyc();
            chk("wait_pc", o_pc, 32'h40);
            chk("wait_req", 32'(o_req), 32'h1);
            chk("wait_valid", 32'(o_valid), 32'h0);
        end
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("ack_ipc", o_instr_pc, 32'h40);
        chk("ack_pc", o_pc, 32'h44);
        cyc();
        chk("nodup_valid", 32'(o_valid), 32'h0);
        chk("nodup_pc", o_pc, 32'h44);

        // PC wrap.
        do_redirect(32'hFFFF_FFFC);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("wrap_pc", o_pc, 32'h0);
        chk("wrap_ipc", o_instr_pc, 32'hFFFF_FFFC);
        cyc();

        // Reset mid-operation after full and re-requesting.
        ready = 1'b0; ack = 1'b1;
        do_redirect(32'h80);
        cyc();
        cyc();
        chk("pre_rst_req", 32'(o_req), 32'h0);
        ready = 1'b1;
        cyc();
        chk("pre_rst_req2", 32'(o_req), 32'h1);
        ready = 1'b0; rst_n = 1'b0;
        cyc();
        chk("mid_rst_pc", o_pc, 32'h0);
        chk("mid_rst_req", 32'(o_req), 32'h0);
        chk("mid_rst_valid", 32'(o_valid), 32'h0);
        chk("mid_rst_instr", o_instr, 32'h0);
        chk("mid_rst_ipc", o_instr_pc, 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_req", 32'(o_req), 32'h1);
        chk("post_rst_pc", o_pc, 32'h0);
        cyc();
        chk("post_rst_ipc", o_instr_pc, 32'h0);
        chk("post_rst_instr", o_instr, 32'h0000_0013);

        // Mixed traffic, checked by the model alone.
        for (int n = 0; n < 300; n++) begin
            ack         = 1'($urandom_range(0, 1));
            ready       = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            rst_n       = ($urandom_range(0, 63) != 0);
            cyc();
        end
        redirect = 1'b0; rst_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
